// File: rtl/shield_spi_arbiter.sv
// Round-robin arbiter sharing one shield SPI slave between two SPI masters.
// Optional grant statistics counters are enabled by defining SHIELD_SPI_ARB_STATS_EN.
module shield_spi_arbiter #(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned TIMEOUT    = 1024,
    parameter bit          CPOL       = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  m_cs_n,
    input  logic [1:0]  m_sck,
    input  logic [1:0]  m_mosi,
    output logic [1:0]  m_miso,
    output logic        bus_cs_n,
    output logic        bus_sck,
    output logic        bus_mosi,
    input  logic        bus_miso,
    output logic        timeout_irq,
    input  logic        irq_clr
`ifdef SHIELD_SPI_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [3:0]  GAP_LAST = 4'(TURNAROUND);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam bit          TO_EN    = (TIMEOUT != 0);

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        rr_q, rr_d;
    logic [1:0]  mask_q, mask_d;
    logic [3:0]  gap_q, gap_d;
    logic [15:0] to_q, to_d;
    logic        irq_q, irq_d;

    logic        own_s;
    logic        own_req_s;
    logic        own_cs_n_s;
    logic [1:0]  elig_s;
    logic        force_s;

    assign own_s      = gnt_q[1];
    assign own_req_s  = req[own_s];
    assign own_cs_n_s = m_cs_n[own_s];
    // A master cut off by timeout stays masked until it is seen with req low.
    assign elig_s     = req & ~mask_q;

    // Arbitration, release and turnaround sequencing.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        gap_d   = gap_q;
        to_d    = to_q;
        force_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gap_d = 4'd0;
                to_d  = 16'd0;
                if (elig_s == 2'b11) begin
                    gnt_d   = rr_q ? 2'b10 : 2'b01;
                    rr_d    = ~rr_q;
                    state_d = ST_OWN;
                end else if (elig_s != 2'b00) begin
                    gnt_d   = elig_s;
                    state_d = ST_OWN;
                end else begin
                    gnt_d = 2'b00;
                end
            end
            ST_OWN: begin
                if (!own_cs_n_s) begin
                    to_d = 16'd0;
                end else begin
                    to_d = to_q + 16'd1;
                end
                if (own_cs_n_s && !own_req_s) begin
                    gnt_d   = 2'b00;
                    state_d = ST_GAP;
                end else if (TO_EN && own_cs_n_s && (to_q == TO_LAST)) begin
                    gnt_d   = 2'b00;
                    state_d = ST_GAP;
                    force_s = 1'b1;
                end else begin
                    gnt_d = gnt_q;
                end
            end
            ST_GAP: begin
                // The release cycle plus TURNAROUND idle cycles keep grants TURNAROUND+2 apart.
                gnt_d = 2'b00;
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Mask bookkeeping and sticky interrupt; a timeout set beats a same-cycle clear.
    always_comb begin
        mask_d = (mask_q & req) | (force_s ? gnt_q : 2'b00);
        if (force_s) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Control state registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            rr_q    <= 1'b0;
            mask_q  <= 2'b00;
            gap_q   <= 4'd0;
            to_q    <= 16'd0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            mask_q  <= mask_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
            irq_q   <= irq_d;
        end
    end

    // Bus mux driven from the registered grant so reset forces CS high at once.
    always_comb begin
        bus_cs_n = 1'b1;
        bus_sck  = CPOL;
        bus_mosi = 1'b0;
        m_miso   = 2'b00;
        if (gnt_q != 2'b00) begin
            bus_cs_n      = m_cs_n[own_s];
            bus_sck       = m_sck[own_s];
            bus_mosi      = m_mosi[own_s];
            m_miso[own_s] = bus_miso;
        end else begin
            bus_cs_n = 1'b1;
            bus_sck  = CPOL;
            bus_mosi = 1'b0;
            m_miso   = 2'b00;
        end
    end

    assign gnt         = gnt_q;
    assign timeout_irq = irq_q;

`ifdef SHIELD_SPI_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Saturating per-master grant counters, cleared alongside the interrupt.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else if (irq_clr) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (gnt_d[0] && !gnt_q[0] && (cnt0_q != 16'hFFFF)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (gnt_d[1] && !gnt_q[1] && (cnt1_q != 16'hFFFF)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule
